// File: rtl/addchk_pkg.sv
// -----------------------------------------------------------------------------
// addchk_pkg
// Shared definitions for the adder response checker:
//   - default WIDTH / LAT / CNT_W values
//   - run-state encoding (IDLE, RUN, DONE)
//   - addchk_exp(): golden a + b + cin with the carry kept as the extra MSB
// The helper works on ADDCHK_MAX_W-bit operands. Callers zero-extend narrower
// operands and keep the low WIDTH+1 bits of the result.
// -----------------------------------------------------------------------------
package addchk_pkg;

    localparam int ADDCHK_WIDTH = 4;
    localparam int ADDCHK_LAT   = 0;
    localparam int ADDCHK_CNT_W = 16;
    localparam int ADDCHK_MAX_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } addchk_state_e;

    // Full-precision sum. Bit [n] of the result is the carry out of an n-bit
    // add whenever both operands fit in n bits.
    function automatic logic [ADDCHK_MAX_W:0] addchk_exp(
        input logic [ADDCHK_MAX_W-1:0] a,
        input logic [ADDCHK_MAX_W-1:0] b,
        input logic                    cin
    );
        return {1'b0, a} + {1'b0, b} + {{ADDCHK_MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/addchk_delay.sv
// -----------------------------------------------------------------------------
// addchk_delay
// LAT-deep valid + payload shift line. It holds the expected result until the
// adder under test produces its output.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valids)
//   clr             synchronous flush of all in-flight entries
//   in_valid/in_data   entry presented this cycle
//   out_valid/out_data entry that entered LAT cycles ago
// Only valid bits are cleared. Payload bits are don't-care while their valid
// bit is low.
// -----------------------------------------------------------------------------
module addchk_delay #(
    parameter int LAT = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] valid_reg;
    logic [W-1:0]   data_reg [LAT];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_reg[0] <= in_data;
        for (int i = 1; i < LAT; i++) begin
            data_reg[i] <= data_reg[i-1];
        end
    end

    assign out_valid = valid_reg[LAT-1];
    assign out_data  = data_reg[LAT-1];

endmodule

// File: rtl/adder_resp_checker.sv
// -----------------------------------------------------------------------------
// adder_resp_checker
// Self-checking monitor for a WIDTH-bit adder with LAT cycles of latency.
// It observes every applied vector (a, b, cin) and the adder's result
// (s, cout), computes the golden {cout,s}, aligns it to the adder latency and
// compares. It counts passes and failures and latches the first failure.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, n_vecs      arm a run of n_vecs compares (n_vecs sampled on start)
//   vec_valid, a, b, cin   vector applied to the adder this cycle
//   sub                (ADDCHK_SUB_EN only) vector is a subtract: a + ~b + cin
//   s, cout            adder result, LAT cycles after its vector
//   busy, done         run in progress / run complete
//   match              one-cycle pulse per correct compare
//   pass_cnt, fail_cnt saturating result counters
//   ff_valid, ff_vec, ff_got   first failing vector and the result observed
//
// Build option: define ADDCHK_SUB_EN to add the sub port and widen ff_vec to
// {sub,a,b,cin}.
// -----------------------------------------------------------------------------
module adder_resp_checker
    import addchk_pkg::*;
#(
    parameter int WIDTH = ADDCHK_WIDTH,
    parameter int LAT   = ADDCHK_LAT,
    parameter int CNT_W = ADDCHK_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_vecs,
    input  logic               vec_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
`ifdef ADDCHK_SUB_EN
    input  logic               sub,
`endif
    input  logic [WIDTH-1:0]   s,
    input  logic               cout,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               ff_valid,
`ifdef ADDCHK_SUB_EN
    output logic [2*WIDTH+1:0] ff_vec,
`else
    output logic [2*WIDTH:0]   ff_vec,
`endif
    output logic [WIDTH:0]     ff_got
);

`ifdef ADDCHK_SUB_EN
    localparam int VEC_W = 2*WIDTH + 2;
`else
    localparam int VEC_W = 2*WIDTH + 1;
`endif
    localparam int PAY_W = VEC_W + WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    addchk_state_e      state_reg;
    logic [CNT_W-1:0]   nvec_reg;
    logic [CNT_W-1:0]   cmp_cnt_reg;
    logic [CNT_W-1:0]   pass_cnt_reg;
    logic [CNT_W-1:0]   fail_cnt_reg;
    logic               match_reg;
    logic               ff_valid_reg;
    logic [VEC_W-1:0]   ff_vec_reg;
    logic [WIDTH:0]     ff_got_reg;

    // Golden result is computed as the vector arrives and travels with it.
    logic [VEC_W-1:0]   in_vec;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     in_exp;
`ifdef ADDCHK_SUB_EN
    assign in_vec = {sub, a, b, cin};
    assign b_eff  = sub ? ~b : b;
`else
    assign in_vec = {a, b, cin};
    assign b_eff  = b;
`endif
    assign in_exp = (WIDTH+1)'(addchk_exp(ADDCHK_MAX_W'(a), ADDCHK_MAX_W'(b_eff), cin));

    logic               in_valid;
    logic               run_start;
    logic               dly_valid;
    logic [PAY_W-1:0]   dly_pay;
    logic [VEC_W-1:0]   dly_vec;
    logic [WIDTH:0]     dly_exp;
    logic               cmp_fire;
    logic               cmp_ok;
    logic               cmp_last;

    // Vectors are only accepted while a run is active.
    assign in_valid  = vec_valid && (state_reg == RUN);
    assign run_start = start && (state_reg != RUN);

    generate
        if (LAT == 0) begin : g_bypass
            assign dly_valid = in_valid;
            assign dly_pay   = {in_vec, in_exp};
        end else begin : g_delay
            // Flush on a new run and on the final compare, so entries still in
            // flight after the last counted vector never reach the comparator.
            addchk_delay #(
                .LAT (LAT),
                .W   (PAY_W)
            ) u_delay (
                .clk       (clk),
                .rst       (rst),
                .clr       (run_start || (cmp_fire && cmp_last)),
                .in_valid  (in_valid),
                .in_data   ({in_vec, in_exp}),
                .out_valid (dly_valid),
                .out_data  (dly_pay)
            );
        end
    endgenerate

    assign dly_vec  = dly_pay[PAY_W-1:WIDTH+1];
    assign dly_exp  = dly_pay[WIDTH:0];
    assign cmp_fire = dly_valid && (state_reg == RUN);
    assign cmp_ok   = ({cout, s} == dly_exp);
    assign cmp_last = ((cmp_cnt_reg + CNT_ONE) == nvec_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            nvec_reg     <= '0;
            cmp_cnt_reg  <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
            match_reg    <= 1'b0;
            ff_valid_reg <= 1'b0;
            ff_vec_reg   <= '0;
            ff_got_reg   <= '0;
        end else begin
            match_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        nvec_reg     <= n_vecs;
                        cmp_cnt_reg  <= '0;
                        pass_cnt_reg <= '0;
                        fail_cnt_reg <= '0;
                        ff_valid_reg <= 1'b0;
                        ff_vec_reg   <= '0;
                        ff_got_reg   <= '0;
                        state_reg    <= (n_vecs == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cmp_fire) begin
                        match_reg   <= cmp_ok;
                        cmp_cnt_reg <= cmp_cnt_reg + CNT_ONE;
                        if (cmp_ok) begin
                            if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + CNT_ONE;
                        end else begin
                            if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + CNT_ONE;
                            if (!ff_valid_reg) begin
                                ff_valid_reg <= 1'b1;
                                ff_vec_reg   <= dly_vec;
                                ff_got_reg   <= {cout, s};
                            end
                        end
                        if (cmp_last) state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign match    = match_reg;
    assign pass_cnt = pass_cnt_reg;
    assign fail_cnt = fail_cnt_reg;
    assign ff_valid = ff_valid_reg;
    assign ff_vec   = ff_vec_reg;
    assign ff_got   = ff_got_reg;

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
Response side of the adder test path: a synthesizable, self-checking monitor that observes each vector applied to a WIDTH-bit ripple adder (a, b, cin) together with the adder's result (s, cout). It computes the golden {cout,s}, aligns it to the adder's latency, compares, counts pass/fail and latches the first failing vector. It sits beside the adder under test on the FPGA lab board, with stimulus from a driver or switches, and reports through LEDs/status.

Parameters:
WIDTH, 4, operand width of a, b, s.
LAT, 0, adder latency in cycles (0..7); 0 = combinational adder, compared in the same cycle as vec_valid.
CNT_W, 16, width of vector, pass and fail counters.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; arms a check run.
n_vecs  in  CNT_W  number of vectors in the run; sampled on start.
vec_valid  in  1  a, b, cin are a new vector this cycle.
a  in  WIDTH  adder operand A as applied.
b  in  WIDTH  adder operand B as applied.
cin  in  1  adder carry-in as applied.
s  in  WIDTH  adder sum output.
cout  in  1  adder carry-out.
busy  out  1  run in progress.
done  out  1  run complete; held until next start or rst.
match  out  1  one-cycle pulse when a compared result is correct.
pass_cnt  out  CNT_W  correct results in the run.
fail_cnt  out  CNT_W  wrong results in the run.
ff_valid  out  1  a first failure has been captured.
ff_vec  out  2*WIDTH+1  {a,b,cin} of the first failure.
ff_got  out  WIDTH+1  {cout,s} observed at the first failure.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-run): state IDLE, all outputs 0, delay line flushed, counters 0.
- FSM IDLE -> RUN on start. In RUN, count compared vectors. RUN -> DONE on the cycle the n_vecs-th compare occurs. DONE -> RUN on start.
- On start: clear counters, ff_*, the delay line and the compare count, and latch n_vecs. If n_vecs=0, go straight to DONE the next cycle.
- start while in RUN is ignored.
- vec_valid is only accepted in RUN. In IDLE and DONE it is ignored, and it enters no delay line.
- Expected value: exp = a + b + cin, computed at WIDTH+1 bits, with the MSB being the expected cout and no truncation.
- Alignment, LAT>0: on vec_valid, {valid,a,b,cin,exp} enters a LAT-deep shift line. Compare {cout,s} in the cycle the entry emerges, so match and counters update LAT cycles after vec_valid plus one register stage.
- Alignment, LAT=0: compare the same-cycle inputs, registered once.
- Vectors may be presented back-to-back every cycle; no stalls.
- Extra vec_valid after the n_vecs-th compare is ignored. Entries still in flight when DONE is entered are discarded.
- Counters saturate at all-ones and do not wrap.
- ff_valid sets on the first mismatch only. Later mismatches leave ff_* unchanged.
- busy = (state==RUN). done = (state==DONE). busy and done are never both 1.

Optional Feature:
ADDCHK_SUB_EN:
- Defined: adds input port sub (1 bit), which travels with the vector through the delay line. When sub=1, exp = a + ~b + cin at WIDTH+1 bits, which checks an adder/subtractor wired as two's-complement subtract with cin=1. ff_vec widens by 1 bit to {sub,a,b,cin}.
- Undefined: no sub port; always add.

Decomposition:
- Package addchk_pkg: state enum {IDLE,RUN,DONE}, default WIDTH/LAT/CNT_W constants, function addchk_exp(a,b,cin).
- Sub-module addchk_delay: parameterised LAT-deep valid+payload shift line with synchronous clear; bypassed when LAT=0.

Test Plan:
- LAT=0, n_vecs=4, correct adder, vectors (0,0,0),(1,0,0),(1,1,0),(1,1,1) -> pass_cnt=4, fail_cnt=0, done=1 one cycle after the 4th vector, ff_valid=0.
- LAT=0, adder carry-out stuck at 0, vector a=F, b=1, cin=0 -> fail_cnt=1, ff_vec={F,1,0}, ff_got=5'b00000.
- LAT=2, 16 back-to-back vectors from a correct adder -> match pulses start 3 cycles after the first vec_valid, pass_cnt=16, done asserted right after the last compare.
- Mid-run rst after 3 of 8 vectors -> next cycle all outputs 0 and state IDLE. A following start plus 8 vectors gives pass_cnt=8.
- n_vecs=0, then start -> done=1 next cycle, counters 0. vec_valid in IDLE/DONE leaves counters unchanged.
- ADDCHK_SUB_EN defined, sub=1, a=3, b=5, cin=1, adder outputs {cout,s}=5'b01110 -> match=1; same vector with sub=0 and that output -> fail_cnt=1.
